// File: rtl/if_id_fetch_stage_if.sv
// Fetch-stage bundle: instruction-memory handshake plus the IF/ID outputs seen by Decode.
// master = fetch stage, slave = memory/decode side.
interface if_id_fetch_stage_if;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemValid;
  logic [31:0] IMemRdata;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;

  modport master (
    output IMemReq, IMemAddr, InstrD, PCD, PCPlus4D, ValidD,
    input  IMemValid, IMemRdata
  );

  modport slave (
    input  IMemReq, IMemAddr, InstrD, PCD, PCPlus4D, ValidD,
    output IMemValid, IMemRdata
  );
endinterface

// File: rtl/if_id_fetch_stage.sv
// Fetch stage + IF/ID register; one request outstanding, instruction lands in IF/ID request+latency cycles later.
// StallD holds PC and IF/ID (a response arriving under stall parks in a one-word skid); bubbles fill every empty slot.
module if_id_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       StallD,
  input  logic                       FlushD,
  input  logic                       PCSrcE,
  input  logic [31:0]                PCTargetE,
  if_id_fetch_stage_if.master        fe
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pcf_q, pcf_d;
  logic [31:0] skid_q, skid_d;
  logic        discard_q, discard_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pcd_q, pcd_d;
  logic [31:0] pcp4_q, pcp4_d;
  logic        valid_q, valid_d;

  logic        deliver;
  logic [31:0] deliver_instr;
  logic [31:0] target_aligned;
  logic [31:0] pcf_plus4;

  assign target_aligned = PCTargetE & ~32'h0000_0003;
  assign pcf_plus4      = pcf_q + 32'd4;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pcf_q     <= RESET_PC;
      skid_q    <= 32'h0;
      discard_q <= 1'b0;
      instr_q   <= NOP_INSTR;
      pcd_q     <= 32'h0;
      pcp4_q    <= 32'h0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pcf_q     <= pcf_d;
      skid_q    <= skid_d;
      discard_q <= discard_d;
      instr_q   <= instr_d;
      pcd_q     <= pcd_d;
      pcp4_q    <= pcp4_d;
      valid_q   <= valid_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pcf_d         = pcf_q;
    skid_d        = skid_q;
    discard_d     = discard_q;
    deliver       = 1'b0;
    deliver_instr = skid_q;

    case (state_q)
      S_IDLE: begin
        state_d = S_ISSUE;
        if (PCSrcE) pcf_d = target_aligned;
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        // the request just issued belongs to the old path; its response must be dropped
        if (PCSrcE) begin
          pcf_d     = target_aligned;
          discard_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (!fe.IMemValid) begin
          if (PCSrcE) begin
            pcf_d     = target_aligned;
            discard_d = 1'b1;
          end
        end else if (discard_q || PCSrcE) begin
          discard_d = 1'b0;
          if (PCSrcE) pcf_d = target_aligned;
          state_d = S_ISSUE;
        end else if (FlushD) begin
          state_d = S_ISSUE;
        end else if (StallD) begin
          skid_d  = fe.IMemRdata;
          state_d = S_HOLD;
        end else begin
          deliver       = 1'b1;
          deliver_instr = fe.IMemRdata;
          pcf_d         = pcf_plus4;
          state_d       = S_ISSUE;
        end
      end
      S_HOLD: begin
        // a flush in HOLD throws away the parked word; same PC is fetched again
        if (PCSrcE) begin
          pcf_d   = target_aligned;
          state_d = S_ISSUE;
        end else if (FlushD) begin
          state_d = S_ISSUE;
        end else if (!StallD) begin
          deliver       = 1'b1;
          deliver_instr = skid_q;
          pcf_d         = pcf_plus4;
          state_d       = S_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    instr_d = instr_q;
    pcd_d   = pcd_q;
    pcp4_d  = pcp4_q;
    valid_d = valid_q;
    if (FlushD || (!StallD && !deliver)) begin
      instr_d = NOP_INSTR;
      pcd_d   = 32'h0;
      pcp4_d  = 32'h0;
      valid_d = 1'b0;
    end else if (!StallD) begin
      instr_d = deliver_instr;
      pcd_d   = pcf_q;
      pcp4_d  = pcf_plus4;
      valid_d = 1'b1;
    end
  end

  always_comb begin
    fe.IMemReq  = (state_q == S_ISSUE);
    fe.IMemAddr = pcf_q;
    fe.InstrD   = instr_q;
    fe.PCD      = pcd_q;
    fe.PCPlus4D = pcp4_q;
    fe.ValidD   = valid_q;
  end

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Directed bench for if_id_fetch_stage: scoreboard of expected IF/ID loads plus
// direct checks of request addresses, bubbles, stall/flush/redirect and PC wrap.
module tb_if_id_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n, rst1_n;
  logic        StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic        stall1, flush1, pcsrc1;
  logic [31:0] target1;

  if_id_fetch_stage_if ifs0 ();
  if_id_fetch_stage_if ifs1 ();

  if_id_fetch_stage dut0 (
    .clk(clk), .rst_n(rst_n), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .fe(ifs0)
  );

  if_id_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk(clk), .rst_n(rst1_n), .StallD(stall1), .FlushD(flush1),
    .PCSrcE(pcsrc1), .PCTargetE(target1), .fe(ifs1)
  );

  int n_pass  = 0;
  int n_total = 0;
  logic [63:0] sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_req(input logic [31:0] exp_addr, input string tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (ifs0.IMemReq === 1'b1) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    check({tag, "_req"}, 32'(found), 32'd1);
    check({tag, "_addr"}, ifs0.IMemAddr, exp_addr);
  endtask

  task automatic respond(input logic [31:0] word, input logic [31:0] pc, input bit push);
    ifs0.IMemValid = 1'b1;
    ifs0.IMemRdata = word;
    if (push) sb.push_back({word, pc});
    tick();
    ifs0.IMemValid = 1'b0;
    ifs0.IMemRdata = 32'h0;
  endtask

  // Every unstalled, unflushed edge that leaves ValidD high is a fresh IF/ID load.
  always @(posedge clk) begin : monitor
    logic        st, fl, live;
    logic [63:0] e;
    st   = StallD;
    fl   = FlushD;
    live = rst_n;
    #1;
    if (live && !st && !fl && ifs0.ValidD === 1'b1) begin
      if (sb.size() == 0) begin
        check("sb_spurious_valid", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check("sb_instr", ifs0.InstrD, e[63:32]);
        check("sb_pcd", ifs0.PCD, e[31:0]);
        check("sb_pcplus4", ifs0.PCPlus4D, e[31:0] + 32'd4);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; rst1_n = 1'b0;
    StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0; PCTargetE = 32'h0;
    stall1 = 1'b0; flush1 = 1'b0; pcsrc1 = 1'b0; target1 = 32'h0;
    ifs0.IMemValid = 1'b0; ifs0.IMemRdata = 32'h0;
    ifs1.IMemValid = 1'b0; ifs1.IMemRdata = 32'h0;

    // reset values
    @(negedge clk);
    check("rst_instr", ifs0.InstrD, NOP);
    check("rst_pcd", ifs0.PCD, 32'h0);
    check("rst_pcp4", ifs0.PCPlus4D, 32'h0);
    check("rst_valid", 32'(ifs0.ValidD), 32'd0);
    check("rst_req", 32'(ifs0.IMemReq), 32'd0);

    // basic 1-cycle memory stream
    rst_n = 1'b1;
    tick();
    wait_req(32'h0, "fetch0");
    tick();
    respond(32'h0050_0093, 32'h0, 1'b1);
    wait_req(32'h4, "fetch1");
    tick();
    check("bubble_valid", 32'(ifs0.ValidD), 32'd0);
    check("bubble_instr", ifs0.InstrD, NOP);
    respond(32'h00A0_0113, 32'h4, 1'b1);
    wait_req(32'h8, "fetch2");

    // stall across the response: HOLD, IF/ID frozen, skid released later
    StallD = 1'b1;
    tick();
    check("stall_hold_instr0", ifs0.InstrD, 32'h00A0_0113);
    check("stall_hold_valid0", 32'(ifs0.ValidD), 32'd1);
    respond(32'h0030_0193, 32'h8, 1'b1);
    check("hold_no_req", 32'(ifs0.IMemReq), 32'd0);
    check("stall_hold_instr1", ifs0.InstrD, 32'h00A0_0113);
    tick();
    check("stall_hold_pcd", ifs0.PCD, 32'h4);
    StallD = 1'b0;
    tick();
    wait_req(32'hC, "after_stall");

    // redirect while a 3-cycle fetch is outstanding
    tick();
    PCSrcE = 1'b1;
    PCTargetE = 32'h0000_0102;
    tick();
    PCSrcE = 1'b0;
    tick();
    respond(32'hBAD0_0093, 32'h0, 1'b0);
    check("redir_drop_valid", 32'(ifs0.ValidD), 32'd0);
    wait_req(32'h0000_0100, "redir");

    // flush coincident with the response: bubble, same PC refetched
    tick();
    FlushD = 1'b1;
    respond(32'h0010_0073, 32'h0, 1'b0);
    FlushD = 1'b0;
    check("flush_instr", ifs0.InstrD, NOP);
    check("flush_valid", 32'(ifs0.ValidD), 32'd0);
    check("flush_pcd", ifs0.PCD, 32'h0);
    wait_req(32'h0000_0100, "flush_refetch");
    tick();
    respond(32'h0010_0073, 32'h0000_0100, 1'b1);
    tick();
    check("sb_drained", 32'(sb.size()), 32'd0);

    // PC wrap with RESET_PC = 0xFFFF_FFFC, then reset mid-WAIT
    rst1_n = 1'b1;
    tick();
    check("wrap_req0", 32'(ifs1.IMemReq), 32'd1);
    check("wrap_addr0", ifs1.IMemAddr, 32'hFFFF_FFFC);
    tick();
    ifs1.IMemValid = 1'b1;
    ifs1.IMemRdata = 32'h0000_0093;
    tick();
    ifs1.IMemValid = 1'b0;
    check("wrap_instr", ifs1.InstrD, 32'h0000_0093);
    check("wrap_pcd", ifs1.PCD, 32'hFFFF_FFFC);
    check("wrap_pcp4", ifs1.PCPlus4D, 32'h0);
    check("wrap_req1", 32'(ifs1.IMemReq), 32'd1);
    check("wrap_addr1", ifs1.IMemAddr, 32'h0);
    tick();
    rst1_n = 1'b0;
    #1;
    check("midrst_instr", ifs1.InstrD, NOP);
    check("midrst_valid", 32'(ifs1.ValidD), 32'd0);
    check("midrst_pcd", ifs1.PCD, 32'h0);
    check("midrst_req", 32'(ifs1.IMemReq), 32'd0);
    tick();
    rst1_n = 1'b1;
    ifs1.IMemValid = 1'b1;
    ifs1.IMemRdata = 32'hBADB_AD93;
    tick();
    ifs1.IMemValid = 1'b0;
    check("late_valid", 32'(ifs1.ValidD), 32'd0);
    check("late_instr", ifs1.InstrD, NOP);
    check("postrst_req", 32'(ifs1.IMemReq), 32'd1);
    check("postrst_addr", ifs1.IMemAddr, 32'hFFFF_FFFC);
    tick();
    check("postrst_valid", 32'(ifs1.ValidD), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/if_id_fetch_stage.md
Name: if_id_fetch_stage

Overview:
- Fetch stage plus IF/ID pipeline register.
- Owns the PC and fetches from instruction memory over a single-outstanding req/valid handshake.
- Produces InstrD, PCD and PCPlus4D for the Decode stage. InstrD[31:7] drives the immediate generator.
- Honours StallD, FlushD and the Execute-stage redirect (PCSrcE/PCTargetE). Injects NOP bubbles whenever no instruction is ready.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- StallD  in  1  hold the IF/ID register and the PC.
- FlushD  in  1  load a bubble into IF/ID.
- PCSrcE  in  1  redirect fetch to PCTargetE.
- PCTargetE  in  32  branch/jump target.
- IMemReq  out  1  one-cycle request pulse.
- IMemAddr  out  32  fetch address; valid while IMemReq=1.
- IMemValid  in  1  response strobe; earliest 1 cycle after the request.
- IMemRdata  in  32  instruction word; valid while IMemValid=1.
- InstrD  out  32  instruction to Decode.
- PCD  out  32  PC of InstrD.
- PCPlus4D  out  32  PCD+4.
- ValidD  out  1  1 = InstrD is a real instruction, 0 = bubble.

Behaviour:
- Reset (async, while rst_n=0):
  - PCF=RESET_PC; state=IDLE; discard=0; skid empty.
  - IMemReq=0; InstrD=NOP_INSTR; PCD=0; PCPlus4D=0; ValidD=0.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
  - IDLE: one cycle after reset deasserts, then -> ISSUE.
  - ISSUE: IMemReq=1, IMemAddr=PCF; -> WAIT next cycle. If PCSrcE=1 in this cycle: PCF<=PCTargetE, discard<=1.
  - WAIT, IMemValid=0: remain in WAIT. If PCSrcE=1: PCF<=PCTargetE, discard<=1.
  - WAIT, IMemValid=1 with discard=1 or PCSrcE=1: drop the response; clear discard; if PCSrcE=1, PCF<=PCTargetE; -> ISSUE.
  - WAIT, IMemValid=1, StallD=0, FlushD=0: IF/ID<={IMemRdata, PCF, PCF+4}; ValidD<=1; PCF<=PCF+4; -> ISSUE.
  - WAIT, IMemValid=1, StallD=1: capture IMemRdata in skid; -> HOLD. PCF unchanged.
  - HOLD, StallD=0 and no redirect: IF/ID<=skid; PCF<=PCF+4; -> ISSUE.
  - HOLD, PCSrcE=1: drop skid; PCF<=PCTargetE; -> ISSUE.
- Redirect and target rules:
  - PCTargetE[1:0] is forced to 2'b00 when loaded into PCF.
  - Priority on PCF: reset > PCSrcE > StallD > increment.
- IF/ID register rules:
  - Priority: reset > FlushD > StallD > load.
  - FlushD=1: InstrD<=NOP_INSTR, ValidD<=0, PCD/PCPlus4D<=0. An instruction delivered in the same cycle is discarded; PCF is not advanced for it and it is refetched unless PCSrcE=1.
  - StallD=1 (no flush): IF/ID holds its contents.
  - No instruction delivered and StallD=0: bubble (NOP_INSTR, ValidD=0).
- Memory protocol:
  - At most one request outstanding.
  - IMemValid outside WAIT is ignored.
  - PCF wraps modulo 2^32 (0xFFFF_FFFC+4 = 0).
- Throughput: with 1-cycle memory latency, one instruction every 2 cycles. Fetch-to-IF/ID latency is the request cycle plus the memory latency.
- Reset mid-operation: all state returns to reset values immediately; a late IMemValid after reset is ignored, because the FSM is in IDLE.

Test Plan:
- Reset, then 1-cycle memory returning {0x00500093, 0x00A00113}: requests at 0x0 and 0x4. InstrD=0x00500093 with PCD=0, PCPlus4D=4, ValidD=1; next InstrD=0x00A00113 with PCD=4. NOP/ValidD=0 in between.
- StallD high for 3 cycles while the response arrives: FSM enters HOLD; IF/ID holds its prior value. On release, InstrD=skid word, and the next request address is +4.
- PCSrcE=1 with PCTargetE=0x0000_0102 while WAIT is outstanding (3-cycle memory): the old response is dropped and never reaches InstrD. Next IMemAddr=0x0000_0100.
- FlushD=1 coincident with IMemValid (rdata 0x00100073): InstrD=0x00000013, ValidD=0. The same PC is refetched.
- RESET_PC=0xFFFF_FFFC: second IMemAddr=0x0000_0000 (wrap). Then rst_n low mid-WAIT with a late IMemValid: outputs stay at reset values, and the first post-reset request is at RESET_PC.
